// File: rtl/multibyte_add_ctrl_pkg.sv
// ============================================================================
// Module   : multibyte_add_ctrl_pkg
// Brief    : Shared types and constants for the byte-serial add/sub controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multibyte_add_ctrl_pkg;

  localparam int BYTE_W         = 8;
  localparam int NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/multibyte_add_ctrl_if.sv
// ============================================================================
// Module   : multibyte_add_ctrl_if
// Brief    : Request/response handshake bundle for multibyte_add_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multibyte_add_ctrl_if
  import multibyte_add_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
);
  localparam int W = BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/multibyte_add_ctrl_hba.sv
// ============================================================================
// Module   : hba
// Brief    : 8-bit hybrid adder - two 4-bit lookahead nibbles, rippled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hba (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [2:0] w_nc;

  assign w_nc[0] = cin;

  for (genvar n = 0; n < 2; n++) begin : g_nib
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g    = a[n*4 +: 4] & b[n*4 +: 4];
    assign w_p    = a[n*4 +: 4] ^ b[n*4 +: 4];
    assign w_c[0] = w_nc[n];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign s[n*4 +: 4] = w_p ^ w_c[3:0];
    assign w_nc[n+1]   = w_c[4];
  end

  assign cout = w_nc[2];

endmodule

`default_nettype wire

// File: rtl/multibyte_add_ctrl.sv
// ============================================================================
// Module   : multibyte_add_ctrl
// Brief    : Byte-serial W-bit add/subtract through a single 8-bit adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multibyte_add_ctrl
  import multibyte_add_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  multibyte_add_ctrl_if.slave bus
);

  localparam int W    = BYTE_W * NBYTES;
  localparam int IDXW = $clog2(NBYTES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NBYTES - 1);

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [IDXW+2:0] w_base;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [7:0]      w_s;
  logic            w_co;
  logic            w_ovf;

  assign w_base   = {r_idx, 3'b000};
  assign w_a_byte = r_a[w_base +: BYTE_W];
  assign w_b_byte = r_b[w_base +: BYTE_W] ^ {BYTE_W{r_sub}};

  hba u_hba (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  // Signed overflow: operands agree in sign but the result does not.
  assign w_ovf = ~(r_a[W-1] ^ (r_b[W-1] ^ r_sub)) & (w_s[7] ^ r_a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sub   <= bus.sub;
            r_carry <= bus.sub;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[w_base +: BYTE_W] <= w_s;
          r_carry                 <= w_co;
          if (r_idx == c_last_idx) begin
            r_cout  <= w_co;
            r_ovf   <= w_ovf;
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_multibyte_add_ctrl.sv
// ============================================================================
// Module   : tb_multibyte_add_ctrl
// Brief    : Directed self-checking bench for multibyte_add_ctrl (NBYTES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multibyte_add_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  multibyte_add_ctrl_if #(.NBYTES(4)) bus ();

  multibyte_add_ctrl #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present a request at the negedge; it is accepted on the next posedge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    chk("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count posedges until out_valid, then check result and retire it.
  task automatic finish_op(input string tag, input logic [31:0] esum,
                           input logic ecout, input logic eovf);
    int lat;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sum"}, bus.sum, esum);
    chk({tag, "_cout"}, bus.cout, ecout);
    chk({tag, "_ovf"}, bus.ovf, eovf);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_retired"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 32'h0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    accept(32'h0000_00FF, 32'h0000_0001, 1'b0);
    finish_op("carry_chain", 32'h0000_0100, 1'b0, 1'b0);

    accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op("pos_ovf", 32'h8000_0000, 1'b0, 1'b1);

    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op("wrap", 32'h0000_0000, 1'b1, 1'b0);

    accept(32'h0000_0000, 32'h0000_0001, 1'b1);
    finish_op("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0);

    accept(32'h0000_0005, 32'h0000_0003, 1'b1);
    finish_op("sub_5_3", 32'h0000_0002, 1'b1, 1'b0);

    accept(32'h8000_0000, 32'h0000_0001, 1'b1);
    finish_op("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: hold out_ready low and poke in_valid while DONE.
    accept(32'h1234_5678, 32'h1111_1111, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid_rise", bus.out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_sum", bus.sum, 32'h2345_6789);
      chk("bp_cout", bus.cout, 1'b0);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_retired", bus.out_valid, 1'b0);
    chk("bp_idle_ready", bus.in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_requeue", bus.out_valid, 1'b0);

    // Reset mid-RUN.
    accept(32'h0000_0010, 32'h0000_0020, 1'b0);
    @(posedge clk);
    #1;
    chk("rr_running", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rr_async_in_ready", bus.in_ready, 1'b1);
    chk("rr_async_out_valid", bus.out_valid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rr_no_valid", bus.out_valid, 1'b0);
    end
    bus.out_ready = 1'b0;
    chk("rr_sum_cleared", bus.sum, 32'h0);
    accept(32'h0000_0001, 32'h0000_0002, 1'b0);
    finish_op("rr_next", 32'h0000_0003, 1'b0, 1'b0);

    // Operand change during RUN must not leak into the result.
    accept(32'h0000_0001, 32'h0000_0001, 1'b0);
    @(negedge clk);
    bus.a        = 32'hFFFF_FFFF;
    bus.b        = 32'h5555_5555;
    bus.sub      = 1'b1;
    bus.in_valid = 1'b1;
    finish_op("op_change", 32'h0000_0002, 1'b0, 1'b0);
    bus.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
